spi_coord_rx: RTL and testbench
===============================

Name: spi_coord_rx

Overview:
- Upstream front end of the Mandelbrot render core.
- Receives one 64-bit coordinate frame over the testbench-driven SPI link (spi_clk, spi_en, spi_data) and rebuilds two 32-bit sign-magnitude words.
- Converts both words to two's-complement Q3.29 and presents the complex point c = real + imag·i to the iteration core with a valid/ready handshake.
- All logic runs in the clk domain; the SPI inputs are oversampled.

Parameters:
- WORD_W, 32, width of each coordinate word.
- FRAC_W, 29, fraction bits per word (1 sign + 2 integer + 29 fraction).
- SYNC_STAGES, 2, synchroniser depth on spi_clk, spi_en and spi_data.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-low.
- spi_clk  in  1  SPI master clock; at least 4 clk periods per spi_clk period.
- spi_en  in  1  frame enable, active high, held for the whole frame.
- spi_data  in  1  serial data; changes on spi_clk falling edge, sampled on rising edge.
- coord_ready  in  1  iteration core can accept a coordinate.
- c_real  out  32  real part, two's-complement Q3.29.
- c_imag  out  32  imaginary part, two's-complement Q3.29.
- coord_valid  out  1  c_real/c_imag hold a complete frame.
- busy  out  1  frame reception in progress.
- frame_err  out  1  one-cycle pulse: short frame or overrun.

Behaviour:
- Reset: all outputs 0, bit counter 0, state IDLE, synchroniser flops 0.
- Input synchronisation:
  - spi_clk, spi_en and spi_data each pass through SYNC_STAGES flops.
  - A rising edge of the synchronised spi_clk (prev 0, now 1) is a sample strobe.
- Frame format:
  - 64 bits, received in time order b0..b63.
  - b0..b31 form the real word, b32..b63 the imaginary word.
  - Within each word the first received bit is the MSB, so the shift register shifts left.
  - Word layout, MSB down: sign, 2 integer bits, 29 fraction bits. Sign-magnitude.
- Conversion (combinational on the completed shift register, registered into c_real/c_imag):
  - sign=0 -> {1'b0, mag[30:0]}.
  - sign=1 -> two's-complement negate of {1'b0, mag[30:0]}.
  - Negative zero (sign=1, mag=0) -> 0x00000000.
- State machine:
  - IDLE: busy=0. Synchronised spi_en rising -> SHIFT, counter cleared. Strobes while spi_en is low are ignored.
  - SHIFT: busy=1.
    - Each strobe shifts in the synchronised spi_data and increments the counter.
    - When the counter reaches 64 -> LOAD.
    - spi_en falling before 64 strobes -> frame_err pulse, data discarded, back to IDLE.
  - LOAD: one cycle; register the converted words; coord_valid=1 -> WAIT_EN.
  - WAIT_EN: extra strobes are ignored. Synchronised spi_en low -> IDLE.
- Handshake:
  - coord_valid is held, with c_real/c_imag stable, until the first cycle where coord_valid and coord_ready are both high.
  - coord_valid clears on the cycle after that transfer.
  - If LOAD occurs while coord_valid is still set (frame not taken): the new frame overwrites the outputs, coord_valid stays 1, and frame_err pulses (overrun).
  - If coord_ready rises in the same cycle as LOAD, the transfer takes the new frame.
- Latency: coord_valid rises 2 clk cycles after the 64th strobe is detected (LOAD register plus output).
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost.

Decomposition:
- Shared package `mandel_pkg`:
  - constants WORD_W, FRAC_W, FRAME_BITS=64;
  - state enum {IDLE, SHIFT, LOAD, WAIT_EN};
  - a `sm_to_tc` function, also used by the core's debug path.
- One sub-module: `sync_edge` (parameterised synchroniser plus rise/fall detector), instantiated for spi_clk and spi_en; spi_data uses the synchroniser only.

Test Plan:
- Reset with nrst=0 for 3 cycles, SPI lines idle -> all outputs 0, busy=0.
- Send all-zero frame with b0=1 ("-0 + 0i"), coord_ready=1 -> coord_valid pulses for 1 cycle; c_real=0x00000000, c_imag=0x00000000.
- Send real = -1.0 (first bits 1,0,1 then 0s) and imag = +0.5 (first bits 0,0,0,1 then 0s), coord_ready=0 -> c_real=0xE0000000, c_imag=0x10000000; coord_valid held; cleared the cycle after coord_ready=1.
- Drop spi_en after 40 bits -> frame_err pulse, coord_valid stays 0, busy=0; the next full frame is received correctly.
- Two back-to-back frames with coord_ready=0 -> frame_err pulse at the second LOAD; outputs show the second frame.
- Assert nrst=0 at bit 20 of a frame -> outputs 0 immediately; after release, a complete frame decodes normally.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared constants, FSM state type and number-format helper for the
// Mandelbrot render core front end.
package mandel_pkg;

    localparam int WORD_W     = 32;
    localparam int FRAC_W     = 29;
    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        WAIT_EN
    } state_t;

    // Sign-magnitude (sign, integer field, fraction field) to two's-complement.
    // A negative zero comes out as 0 because negating 0 yields 0.
    function automatic logic [WORD_W-1:0] sm_to_tc(input logic [WORD_W-1:0] sm);
        logic [WORD_W-1:0] mag;
        mag = {1'b0, sm[WORD_W-2:FRAC_W], sm[FRAC_W-1:0]};
        return sm[WORD_W-1] ? (~mag + {{(WORD_W-1){1'b0}}, 1'b1}) : mag;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the asynchronous input through the chain and remember the last level.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_coord_rx.sv
// Oversampled SPI receiver: collects a 64-bit coordinate frame, converts the
// two sign-magnitude words to two's-complement Q3.29 and offers them to the
// iteration core over a valid/ready handshake.
module spi_coord_rx
    import mandel_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              spi_clk,
    input  logic              spi_en,
    input  logic              spi_data,
    input  logic              coord_ready,
    output logic [WORD_W-1:0] c_real,
    output logic [WORD_W-1:0] c_imag,
    output logic              coord_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS) + 1;

    logic                   sclk_s, sclk_rise, sclk_fall;
    logic                   en_s, en_rise, en_fall;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   data_s;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [WORD_W-1:0]       real_tc, imag_tc;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .nrst (nrst),
        .din  (spi_clk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk  (clk),
        .nrst (nrst),
        .din  (spi_en),
        .dout (en_s),
        .rise (en_rise),
        .fall (en_fall)
    );

    // Data only needs the same delay as spi_clk so it lines up with the strobe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_sync <= '0;
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
        end
    end

    assign data_s = data_sync[SYNC_STAGES-1];

    // First bit received sits in the MSB of each word.
    assign real_tc = sm_to_tc(shift_reg[FRAME_BITS-1:WORD_W]);
    assign imag_tc = sm_to_tc(shift_reg[WORD_W-1:0]);

    // Frame FSM with registered outputs and the output handshake.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: the datapath is reset along with control so that a reset
            // mid-frame leaves c_real/c_imag at 0, not at stale frame data.
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            c_real      <= '0;
            c_imag      <= '0;
            coord_valid <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // NOTE: later assignments in this block override the defaults
            // below; non-blocking keeps every read on pre-edge values.
            frame_err <= 1'b0;
            if (coord_valid && coord_ready) begin
                coord_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en_rise) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (en_fall) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], data_s};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    c_real      <= real_tc;
                    c_imag      <= imag_tc;
                    coord_valid <= 1'b1;
                    // Previous frame still unclaimed and not leaving this cycle.
                    if (coord_valid && !coord_ready) begin
                        frame_err <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= WAIT_EN;
                end
                WAIT_EN: begin
                    if (!en_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_coord_rx.sv
// Randomised scoreboard bench for spi_coord_rx: expected coordinates are queued
// when a frame is sent and checked by a monitor whenever a transfer happens.
module tb_spi_coord_rx;

    logic        tb_clk;
    logic        nrst;
    logic        spi_clk, spi_en, spi_data;
    logic        coord_ready;
    logic [31:0] c_real, c_imag;
    logic        coord_valid, busy, frame_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_seen = 0;
    int          err_exp  = 0;
    int          valid_cycles = 0;
    bit          rand_ready = 0;
    logic [63:0] exp_q[$];

    spi_coord_rx #(.SYNC_STAGES(2)) dut (
        .clk         (tb_clk),
        .nrst        (nrst),
        .spi_clk     (spi_clk),
        .spi_en      (spi_en),
        .spi_data    (spi_data),
        .coord_ready (coord_ready),
        .c_real      (c_real),
        .c_imag      (c_imag),
        .coord_valid (coord_valid),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Sign-magnitude value read as a signed number, then written as 32-bit two's complement.
    function automatic logic [31:0] model_word(input logic [31:0] sm);
        longint      mag, v;
        logic [63:0] t;
        mag = longint'(sm & 32'h7FFF_FFFF);
        v   = sm[31] ? -mag : mag;
        t   = 64'(v);
        return t[31:0];
    endfunction

    function automatic logic [63:0] model_frame(input logic [63:0] frame);
        return {model_word(frame[63:32]), model_word(frame[31:0])};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    // Bit i of the frame in time order is frame[63-i]; data moves while spi_clk is low.
    task automatic send_frame(input logic [63:0] frame, input int nbits, input bit drop_en);
        spi_en = 1'b1;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            spi_clk  = 1'b0;
            spi_data = frame[63-i];
            wait_clks(4);
            spi_clk = 1'b1;
            wait_clks(4);
        end
        spi_clk = 1'b0;
        wait_clks(4);
        if (drop_en) begin
            spi_en   = 1'b0;
            spi_data = 1'b0;
            wait_clks(8);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) wait_clks(1);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every accepted transfer is matched against the oldest expectation.
    always @(negedge tb_clk) begin
        if (nrst) begin
            if (frame_err) err_seen++;
            if (coord_valid) valid_cycles++;
            if (coord_valid && coord_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_transfer: got %h_%h, expected no transfer", c_real, c_imag);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("xfer_real", 64'(c_real), 64'(e[63:32]));
                    check("xfer_imag", 64'(c_imag), 64'(e[31:0]));
                end
            end
        end
    end

    // Random back-pressure during the randomised phase.
    initial begin
        forever begin
            @(posedge tb_clk);
            #1;
            if (rand_ready) coord_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] f, fa, fb, e;
        int          vc0, e0;

        nrst = 1'b0; spi_clk = 1'b0; spi_en = 1'b0; spi_data = 1'b0; coord_ready = 1'b0;
        wait_clks(3);
        check("rst_c_real", 64'(c_real), 64'd0);
        check("rst_c_imag", 64'(c_imag), 64'd0);
        check("rst_valid", 64'(coord_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        nrst = 1'b1;
        wait_clks(4);

        // Negative zero on the real part, ready always high: one-cycle valid.
        coord_ready = 1'b1;
        vc0 = valid_cycles;
        f = 64'h8000_0000_0000_0000;
        exp_q.push_back(model_frame(f));
        send_frame(f, 64, 1'b1);
        check("negzero_valid_cycles", 64'(valid_cycles - vc0), 64'd1);
        wait_drain("negzero_drain");

        // -1.0 + 0.5i held until ready.
        coord_ready = 1'b0;
        f = {32'hA000_0000, 32'h1000_0000};
        exp_q.push_back(model_frame(f));
        send_frame(f, 64, 1'b1);
        check("hold_valid", 64'(coord_valid), 64'd1);
        check("hold_real", 64'(c_real), 64'hE000_0000);
        check("hold_imag", 64'(c_imag), 64'h1000_0000);
        wait_clks(5);
        check("hold_valid_later", 64'(coord_valid), 64'd1);
        check("hold_real_later", 64'(c_real), 64'hE000_0000);
        coord_ready = 1'b1;
        wait_clks(1);
        check("valid_cleared_after_xfer", 64'(coord_valid), 64'd0);
        wait_drain("hold_drain");

        // Short frame: 40 bits then spi_en drops.
        e0 = err_seen;
        f = {$urandom, $urandom};
        send_frame(f, 40, 1'b1);
        err_exp++;
        check("short_frame_err", 64'(err_seen - e0), 64'd1);
        check("short_valid", 64'(coord_valid), 64'd0);
        check("short_busy", 64'(busy), 64'd0);
        f = {$urandom, $urandom};
        exp_q.push_back(model_frame(f));
        send_frame(f, 64, 1'b1);
        wait_drain("after_short_drain");

        // Overrun: two frames with no ready; only the second survives.
        coord_ready = 1'b0;
        fa = {$urandom, $urandom};
        fb = {$urandom, $urandom};
        e0 = err_seen;
        exp_q.push_back(model_frame(fb));
        send_frame(fa, 64, 1'b1);
        send_frame(fb, 64, 1'b1);
        err_exp++;
        e = model_frame(fb);
        check("overrun_err", 64'(err_seen - e0), 64'd1);
        check("overrun_valid", 64'(coord_valid), 64'd1);
        check("overrun_real", 64'(c_real), 64'(e[63:32]));
        check("overrun_imag", 64'(c_imag), 64'(e[31:0]));
        coord_ready = 1'b1;
        wait_drain("overrun_drain");

        // Reset at bit 20 of a frame.
        f = {$urandom, $urandom};
        send_frame(f, 20, 1'b0);
        nrst = 1'b0;
        #1;
        check("midrst_c_real", 64'(c_real), 64'd0);
        check("midrst_c_imag", 64'(c_imag), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(coord_valid), 64'd0);
        spi_en = 1'b0; spi_data = 1'b0;
        wait_clks(2);
        nrst = 1'b1;
        wait_clks(4);
        f = {$urandom, $urandom};
        exp_q.push_back(model_frame(f));
        send_frame(f, 64, 1'b1);
        wait_drain("after_rst_drain");

        // Randomised frames with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f = {$urandom, $urandom};
            if (i % 4 == 0) f[63:32] = 32'h8000_0000;
            if (i % 4 == 1) f[31:0]  = 32'h8000_0000;
            exp_q.push_back(model_frame(f));
            send_frame(f, 64, 1'b1);
            wait_drain("rand_drain");
        end
        rand_ready = 1'b0;
        wait_clks(2);

        check("frame_err_total", 64'(err_seen), 64'(err_exp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
